// File: rtl/uart_instr_rx.sv
// UART instruction receiver: two 8N1 bytes (high byte first) form one 15-bit
// instruction, buffered in a first-word-fall-through FIFO with a valid/ready handshake.
module uart_instr_rx #(
  parameter int unsigned BAUD_DIVIDER = 434,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        rx,
  output logic [14:0]                 instr_out,
  output logic                        instr_valid,
  input  logic                        instr_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        frame_error,
  output logic                        proto_error,
  output logic                        overflow
);

  localparam int unsigned CNT_W      = $clog2(BAUD_DIVIDER);
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
  localparam int unsigned FCNT_W     = PTR_W + 1;
  localparam int unsigned TMO_CYCLES = TIMEOUT_BITS * BAUD_DIVIDER;
  localparam int unsigned TMO_W      = (TMO_CYCLES > 2) ? $clog2(TMO_CYCLES) : 1;

  // The IDLE cycle that spots the low rxs counts toward the half-bit wait.
  localparam logic [CNT_W-1:0]  START_LAST = CNT_W'(BAUD_DIVIDER / 2 - 2);
  localparam logic [CNT_W-1:0]  BIT_LAST   = CNT_W'(BAUD_DIVIDER - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST   = TMO_W'(TMO_CYCLES - 1);
  localparam logic [FCNT_W-1:0] FULL_CNT   = FCNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } rx_state_e;

  logic              rx_meta_q;
  logic              rxs_q;
  rx_state_e         state_q;
  logic [CNT_W-1:0]  baud_cnt_q;
  logic [2:0]        bit_cnt_q;
  logic [7:0]        shift_q;
  logic              byte_vld_q;
  logic              frame_error_q;

  logic              expect_lo_q;
  logic [6:0]        hi_q;
  logic [TMO_W-1:0]  tmo_q;
  logic              proto_error_q;

  logic [14:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [FCNT_W-1:0] count_q;
  logic [FCNT_W-1:0] count_d;
  logic [14:0]       head_q;
  logic [14:0]       head_d;
  logic              valid_q;
  logic              overflow_q;

  logic              push_c;
  logic              push_ok_c;
  logic              pop_c;
  logic              full_c;
  logic [14:0]       word_c;

  // Two-flop synchroniser, idles high so reset never looks like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rxs_q     <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      baud_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      byte_vld_q    <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      byte_vld_q    <= 1'b0;
      frame_error_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!rxs_q) begin
            state_q    <= S_START;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
          end
        end
        S_START: begin
          if (baud_cnt_q == START_LAST) begin
            baud_cnt_q <= '0;
            state_q    <= rxs_q ? S_IDLE : S_DATA;
          end else begin
            baud_cnt_q <= baud_cnt_q + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (baud_cnt_q == BIT_LAST) begin
            baud_cnt_q <= '0;
            shift_q    <= {rxs_q, shift_q[7:1]};
            bit_cnt_q  <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_q <= S_STOP;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (baud_cnt_q == BIT_LAST) begin
            baud_cnt_q <= '0;
            if (rxs_q) begin
              byte_vld_q <= 1'b1;
              state_q    <= S_IDLE;
            end else begin
              frame_error_q <= 1'b1;
              state_q       <= S_WAIT_HIGH;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + CNT_W'(1);
          end
        end
        S_WAIT_HIGH: begin
          if (rxs_q) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Byte-pair assembler; the low-byte timeout only runs while the line idles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      expect_lo_q   <= 1'b0;
      hi_q          <= '0;
      tmo_q         <= '0;
      proto_error_q <= 1'b0;
    end else begin
      proto_error_q <= 1'b0;
      if (frame_error_q) begin
        expect_lo_q <= 1'b0;
      end else if (byte_vld_q) begin
        if (expect_lo_q) begin
          expect_lo_q <= 1'b0;
        end else if (shift_q[7]) begin
          proto_error_q <= 1'b1;
        end else begin
          hi_q        <= shift_q[6:0];
          expect_lo_q <= 1'b1;
          tmo_q       <= '0;
        end
      end else if (expect_lo_q && (state_q == S_IDLE) && rxs_q) begin
        if (tmo_q == TMO_LAST) begin
          proto_error_q <= 1'b1;
          expect_lo_q   <= 1'b0;
        end else begin
          tmo_q <= tmo_q + TMO_W'(1);
        end
      end
    end
  end

  // FIFO next state; head_q mirrors mem at rd_ptr so the output stays registered.
  always_comb begin
    pop_c     = valid_q && instr_ready;
    push_c    = byte_vld_q && expect_lo_q;
    full_c    = (count_q == FULL_CNT);
    push_ok_c = push_c && (!full_c || pop_c);
    word_c    = {hi_q, shift_q};
    count_d   = count_q;
    head_d    = head_q;
    if (push_ok_c && !pop_c) begin
      count_d = count_q + FCNT_W'(1);
    end else if (pop_c && !push_ok_c) begin
      count_d = count_q - FCNT_W'(1);
    end
    if (pop_c) begin
      if (count_q == FCNT_W'(1)) begin
        head_d = push_ok_c ? word_c : 15'h0;
      end else begin
        head_d = mem_q[rd_ptr_q + PTR_W'(1)];
      end
    end else if (push_ok_c && (count_q == '0)) begin
      head_d = word_c;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      head_q     <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      valid_q <= (count_d != '0);
      if (push_ok_c) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (push_c && !push_ok_c) begin
        overflow_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok_c) begin
      mem_q[wr_ptr_q] <= word_c;
    end
  end

  assign instr_out   = head_q;
  assign instr_valid = valid_q;
  assign fifo_count  = count_q;
  assign frame_error = frame_error_q;
  assign proto_error = proto_error_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_uart_instr_rx.sv
// Bench for uart_instr_rx: directed scenarios plus random frames, checked every
// cycle against a frame-level model of the receiver, assembler and FIFO.
module tb_uart_instr_rx;

  localparam int BAUD     = 16;
  localparam int DEPTH    = 4;
  localparam int TBITS    = 20;
  localparam int HALF     = BAUD / 2;
  localparam int SYNC     = 2;
  localparam int STOP_OFS = SYNC + HALF + 9 * BAUD;
  localparam int TMO      = TBITS * BAUD;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx = 1'b1;
  logic        instr_ready = 1'b0;
  logic [14:0] instr_out;
  logic        instr_valid;
  logic [2:0]  fifo_count;
  logic        frame_error;
  logic        proto_error;
  logic        overflow;

  uart_instr_rx #(
    .BAUD_DIVIDER(BAUD),
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT_BITS(TBITS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .instr_out  (instr_out),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .fifo_count (fifo_count),
    .frame_error(frame_error),
    .proto_error(proto_error),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         c;
    logic [7:0] b;
    bit         ok;
  } frame_t;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  bit          cmp_en = 0;
  int          fe_seen = 0;
  int          pe_seen = 0;

  frame_t      frames[$];
  logic [14:0] mq[$];
  bit          pend_lo = 0;
  logic [6:0]  m_hi = '0;
  int          lo_start = -1;
  int          deadline = 0;
  bit          m_ovf = 0;
  bit          m_fe = 0;
  bit          m_pe = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame-level model, evaluated once per rising edge.
  task automatic model_step();
    bit          pop;
    bit          push;
    logic [14:0] w;
    pop  = (mq.size() != 0) && instr_ready;
    push = 0;
    w    = '0;
    foreach (frames[i]) begin
      if (frames[i].c + SYNC + 1 == cyc && pend_lo && lo_start < 0) lo_start = frames[i].c;
    end
    if (pend_lo && lo_start < 0 && cyc == deadline) begin
      m_pe    = 1;
      pend_lo = 0;
    end
    foreach (frames[i]) begin
      if (frames[i].c + STOP_OFS == cyc && !frames[i].ok) begin
        m_fe    = 1;
        pend_lo = 0;
      end
      if (frames[i].c + STOP_OFS + 1 == cyc && frames[i].ok) begin
        if (pend_lo) begin
          push    = 1;
          w       = {m_hi, frames[i].b};
          pend_lo = 0;
        end else if (frames[i].b[7]) begin
          m_pe = 1;
        end else begin
          m_hi     = frames[i].b[6:0];
          pend_lo  = 1;
          lo_start = -1;
          deadline = cyc + TMO;
        end
      end
    end
    while (frames.size() != 0 && frames[0].c + STOP_OFS + 1 <= cyc) void'(frames.pop_front());
    if (push && mq.size() == DEPTH && !pop) m_ovf = 1;
    else if (push && pop) begin void'(mq.pop_front()); mq.push_back(w); end
    else if (push) mq.push_back(w);
    else if (pop) void'(mq.pop_front());
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      m_fe = 0;
      m_pe = 0;
      if (!reset) model_step();
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("instr_out", 32'(instr_out), (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
      chk("instr_valid", 32'(instr_valid), 32'(mq.size() != 0));
      chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
      chk("frame_error", 32'(frame_error), 32'(m_fe));
      chk("proto_error", 32'(proto_error), 32'(m_pe));
      chk("overflow", 32'(overflow), 32'(m_ovf));
    end
    if (frame_error) fe_seen++;
    if (proto_error) pe_seen++;
  end

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit ok);
    frame_t f;
    f.c  = cyc;
    f.b  = b;
    f.ok = ok;
    frames.push_back(f);
    rx = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wait_cycles(BAUD);
      rx = b[i];
    end
    wait_cycles(BAUD);
    rx = ok;
    wait_cycles(BAUD);
    rx = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rx = 1'b1;
    instr_ready = 1'b0;
    frames.delete();
    mq.delete();
    pend_lo = 0;
    lo_start = -1;
    m_ovf = 0;
    m_fe = 0;
    m_pe = 0;
    #1;
    chk("rst_instr_out", 32'(instr_out), 32'h0);
    chk("rst_instr_valid", 32'(instr_valid), 32'h0);
    chk("rst_fifo_count", 32'(fifo_count), 32'h0);
    chk("rst_frame_error", 32'(frame_error), 32'h0);
    chk("rst_proto_error", 32'(proto_error), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    wait_cycles(2);
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int          fe0;
    int          pe0;
    logic [14:0] w;
    bit          rand_done;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cmp_en = 1;

    // 1: single instruction, then one-cycle pop
    do_reset();
    send_frame(8'h4A, 1);
    send_frame(8'h35, 1);
    wait_cycles(2);
    chk("t1_instr_out", 32'(instr_out), 32'h4A35);
    chk("t1_valid", 32'(instr_valid), 32'h1);
    chk("t1_count", 32'(fifo_count), 32'h1);
    instr_ready = 1'b1;
    wait_cycles(1);
    instr_ready = 1'b0;
    chk("t1_count_pop", 32'(fifo_count), 32'h0);
    chk("t1_valid_pop", 32'(instr_valid), 32'h0);
    chk("t1_out_pop", 32'(instr_out), 32'h0);

    // 2: five pairs into a depth-4 FIFO, then drain in order
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1);
      send_frame(8'(i * 17), 1);
    end
    wait_cycles(2);
    chk("t2_count", 32'(fifo_count), 32'h4);
    chk("t2_overflow", 32'(overflow), 32'h1);
    instr_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      w = {7'(k), 8'(k * 17)};
      chk("t2_drain", 32'(instr_out), 32'(w));
      wait_cycles(1);
    end
    instr_ready = 1'b0;
    chk("t2_empty", 32'(instr_valid), 32'h0);

    // 3: framing error on the low byte discards the pair
    do_reset();
    fe0 = fe_seen;
    send_frame(8'h12, 1);
    send_frame(8'h34, 0);
    wait_cycles(8);
    chk("t3_fe_pulses", 32'(fe_seen - fe0), 32'h1);
    chk("t3_no_push", 32'(fifo_count), 32'h0);
    send_frame(8'h12, 1);
    send_frame(8'h34, 1);
    wait_cycles(2);
    chk("t3_instr_out", 32'(instr_out), 32'h1234);

    // 4: bad high byte, low-byte timeout, then a clean pair
    do_reset();
    pe0 = pe_seen;
    send_frame(8'h80, 1);
    wait_cycles(2);
    chk("t4_pe_badhi", 32'(pe_seen - pe0), 32'h1);
    chk("t4_no_push", 32'(fifo_count), 32'h0);
    send_frame(8'h12, 1);
    wait_cycles(TMO + 10);
    chk("t4_pe_timeout", 32'(pe_seen - pe0), 32'h2);
    send_frame(8'h7F, 1);
    send_frame(8'hFF, 1);
    wait_cycles(2);
    chk("t4_instr_out", 32'(instr_out), 32'h7FFF);
    chk("t4_pe_total", 32'(pe_seen - pe0), 32'h2);

    // 5: short glitch, then reset in the middle of a data bit
    do_reset();
    fe0 = fe_seen;
    pe0 = pe_seen;
    rx = 1'b0;
    wait_cycles(4);
    rx = 1'b1;
    wait_cycles(3 * BAUD);
    chk("t5_glitch_count", 32'(fifo_count), 32'h0);
    chk("t5_glitch_err", 32'((fe_seen - fe0) + (pe_seen - pe0)), 32'h0);
    send_frame(8'h11, 1);
    send_frame(8'h22, 1);
    wait_cycles(2);
    chk("t5_pre_reset", 32'(instr_out), 32'h1122);
    rx = 1'b0;
    wait_cycles(BAUD + 3 * BAUD + HALF);
    do_reset();
    send_frame(8'h00, 1);
    send_frame(8'h01, 1);
    wait_cycles(2);
    chk("t5_instr_out", 32'(instr_out), 32'h0001);

    // Random frames, gaps and consumer back-pressure
    do_reset();
    rand_done = 0;
    fork
      begin
        for (int n = 0; n < 48; n++) begin
          logic [7:0] b;
          bit         ok;
          b = 8'($urandom);
          if ($urandom_range(0, 3) != 0) b[7] = 1'b0;
          ok = ($urandom_range(0, 9) != 0);
          send_frame(b, ok);
          if (!ok) wait_cycles(4 + int'($urandom_range(0, 20)));
          else if ($urandom_range(0, 5) == 0) wait_cycles(int'($urandom_range(290, 340)));
          else wait_cycles(int'($urandom_range(0, 5)));
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          instr_ready = ($urandom_range(0, 2) == 0);
        end
      end
    join
    instr_ready = 1'b1;
    wait_cycles(20);
    chk("rand_drained", 32'(fifo_count), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
